// File: rtl/display_pkg.sv
// Shared widths, colour defaults and the sprite descriptor for the wave compositor.
package display_pkg;
  localparam int HC_W  = 11;
  localparam int VC_W  = 10;
  localparam int RGB_W = 12;
  localparam int SPR_W = 8;

  localparam logic [RGB_W-1:0] SKY_RGB_DEF  = 12'hFFF;
  localparam logic [RGB_W-1:0] SEA_RGB_DEF  = 12'h00F;
  localparam logic [RGB_W-1:0] LINE_RGB_DEF = 12'hFF0;

  // Field order matches the concatenation used to unpack the flat spr_* buses.
  typedef struct packed {
    logic [HC_W-1:0]  x;
    logic [VC_W-1:0]  y;
    logic [SPR_W-1:0] w;
    logic [SPR_W-1:0] h;
    logic [RGB_W-1:0] rgb;
  } spr_t;
endpackage

// File: rtl/sprite_box.sv
// Registered hit test for one sprite channel; also carries the channel colour to stage 2.
module sprite_box
  import display_pkg::*;
(
  input  logic             vclock,
  input  logic             reset,
  input  logic [HC_W-1:0]  hcount,
  input  logic [VC_W-1:0]  vcount,
  input  spr_t             spr,
  output logic             hit,
  output logic [RGB_W-1:0] rgb
);
  logic [HC_W:0] x_end;
  logic [VC_W:0] y_end;
  logic          hit_d;

  // One extra bit on the far edges so x+w / y+h never wrap.
  assign x_end = {1'b0, spr.x} + {{(HC_W+1-SPR_W){1'b0}}, spr.w};
  assign y_end = {1'b0, spr.y} + {{(VC_W+1-SPR_W){1'b0}}, spr.h};

  assign hit_d = (spr.rgb != '0) &&
                 (hcount >= spr.x) && ({1'b0, hcount} < x_end) &&
                 (vcount >= spr.y) && ({1'b0, vcount} < y_end);

  always_ff @(posedge vclock) begin
    if (reset) begin
      hit <= 1'b0;
      rgb <= '0;
    end else begin
      hit <= hit_d;
      rgb <= spr.rgb;
    end
  end
endmodule

// File: rtl/wave_compositor.sv
// Per-pixel compositor: N_SPR sprites over a sky/sea background split by a ping-pong wave profile.
// Optional macro WAVE_LINE_EN draws the profile row in LINE_RGB.
module wave_compositor
  import display_pkg::*;
#(
  parameter int               N_SPR     = 4,
  parameter int               LOG_DEPTH = 10,
  parameter logic [RGB_W-1:0] SKY_RGB   = SKY_RGB_DEF,
  parameter logic [RGB_W-1:0] SEA_RGB   = SEA_RGB_DEF,
  parameter logic [RGB_W-1:0] LINE_RGB  = LINE_RGB_DEF
) (
  input  logic                     vclock,
  input  logic                     reset,
  input  logic [HC_W-1:0]          hcount,
  input  logic [VC_W-1:0]          vcount,
  input  logic                     vsync,
  input  logic                     blank,
  input  logic [VC_W-1:0]          wave_prof,
  input  logic                     wave_valid,
  output logic                     wave_ready,
  input  logic [HC_W*N_SPR-1:0]    spr_x,
  input  logic [VC_W*N_SPR-1:0]    spr_y,
  input  logic [SPR_W*N_SPR-1:0]   spr_w,
  input  logic [SPR_W*N_SPR-1:0]   spr_h,
  input  logic [RGB_W*N_SPR-1:0]   spr_rgb,
  output logic                     frame_drop,
  output logic [RGB_W-1:0]         p_rgb
);
  localparam int DEPTH = 2**LOG_DEPTH;

  logic                 vsync_q, frame_ev, xfer;
  logic                 bank, full, ready_q, drop_q;
  logic [LOG_DEPTH-1:0] idx;

  logic [VC_W-1:0]      ram [0:2*DEPTH-1];
  logic [VC_W-1:0]      prof_q, vc_q;
  logic                 blank_q;

  spr_t [N_SPR-1:0]              spr_in, shadow;
  logic [N_SPR-1:0]              hit;
  logic [N_SPR-1:0][RGB_W-1:0]   hit_rgb;
  logic [RGB_W-1:0]              pix_d;

  assign frame_ev   = vsync_q & ~vsync;
  assign xfer       = wave_valid & ready_q & ~reset;
  assign wave_ready = ready_q;
  assign frame_drop = drop_q;

  always_ff @(posedge vclock) vsync_q <= vsync;

  // Loader, bank swap and sprite shadow latch.
  always_ff @(posedge vclock) begin
    if (reset) begin
      bank    <= 1'b0;
      idx     <= '0;
      full    <= 1'b0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
      shadow  <= '0;
    end else begin
      drop_q  <= frame_ev & ~full;
      ready_q <= ~full;
      if (frame_ev) shadow <= spr_in;
      if (frame_ev && full) begin
        bank    <= ~bank;
        idx     <= '0;
        full    <= 1'b0;
        ready_q <= 1'b1;
      end else if (xfer) begin
        idx <= idx + LOG_DEPTH'(1);
        if (&idx) begin
          full    <= 1'b1;
          ready_q <= 1'b0;
        end
      end
    end
  end

  // Back bank is ~bank; the front bank is read by column and wraps past DEPTH.
  always_ff @(posedge vclock) begin
    if (xfer) ram[{~bank, idx}] <= wave_prof;
    prof_q <= ram[{bank, hcount[LOG_DEPTH-1:0]}];
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      vc_q    <= '0;
      blank_q <= 1'b1;
    end else begin
      vc_q    <= vcount;
      blank_q <= blank;
    end
  end

  for (genvar k = 0; k < N_SPR; k++) begin : g_spr
    assign spr_in[k] = {spr_x[k*HC_W +: HC_W], spr_y[k*VC_W +: VC_W],
                        spr_w[k*SPR_W +: SPR_W], spr_h[k*SPR_W +: SPR_W],
                        spr_rgb[k*RGB_W +: RGB_W]};
    sprite_box u_box (
      .vclock (vclock),
      .reset  (reset),
      .hcount (hcount),
      .vcount (vcount),
      .spr    (shadow[k]),
      .hit    (hit[k]),
      .rgb    (hit_rgb[k])
    );
  end

  // Background first, then sprites from lowest priority up so channel 0 wins.
  always_comb begin
    pix_d = SKY_RGB;
    if (vc_q > prof_q) pix_d = SEA_RGB;
`ifdef WAVE_LINE_EN
    else if (vc_q == prof_q) pix_d = LINE_RGB;
`endif
    for (int k = N_SPR-1; k >= 0; k--)
      if (hit[k]) pix_d = hit_rgb[k];
    if (blank_q) pix_d = '0;
  end

  always_ff @(posedge vclock) begin
    if (reset) p_rgb <= '0;
    else       p_rgb <= pix_d;
  end
endmodule

// File: tb/tb_wave_compositor.sv
// Self-checking bench for wave_compositor: behavioural frame/loader model plus directed literal pixels.
module tb_wave_compositor;
  localparam int N = 4;
  localparam int LD = 10;
  localparam int DEPTH = 1024;
`ifdef WAVE_LINE_EN
  localparam bit LINE = 1'b1;
`else
  localparam bit LINE = 1'b0;
`endif

  logic             vclock = 1'b0;
  logic             reset = 1'b1;
  logic [10:0]      hcount = '0;
  logic [9:0]       vcount = '0;
  logic             vsync = 1'b1;
  logic             blank = 1'b0;
  logic [9:0]       wave_prof = '0;
  logic             wave_valid = 1'b0;
  logic             wave_ready;
  logic [11*N-1:0]  spr_x = '0;
  logic [10*N-1:0]  spr_y = '0;
  logic [8*N-1:0]   spr_w = '0;
  logic [8*N-1:0]   spr_h = '0;
  logic [12*N-1:0]  spr_rgb = '0;
  logic             frame_drop;
  logic [11:0]      p_rgb;

  wave_compositor #(.N_SPR(N), .LOG_DEPTH(LD)) dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .vsync(vsync), .blank(blank), .wave_prof(wave_prof), .wave_valid(wave_valid),
    .wave_ready(wave_ready), .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w),
    .spr_h(spr_h), .spr_rgb(spr_rgb), .frame_drop(frame_drop), .p_rgb(p_rgb)
  );

  always #5 vclock = ~vclock;

  int checks = 0;
  int failures = 0;
  int drops = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: two profile tables, the front one selected by m_bank.
  int mem [2][DEPTH];
  bit memv [2][DEPTH];
  int m_bank = 0, m_idx = 0;
  bit m_full = 0, m_rdy = 0, m_drop = 0, m_vsq = 1, started = 0;
  int sx[N], sy[N], sw[N], sh[N], sc[N];
  int e1 = 0, e2 = 0;
  bit e1v = 0, e2v = 0;

  always @(posedge vclock) begin
    int px, a, h, v;
    bit pv, fe, xf, fo, found;
    e2 = e1; e2v = e1v;
    if (reset) begin
      started = 1;
      e1 = 0; e1v = 1; e2 = 0; e2v = 1;
      m_bank = 0; m_idx = 0; m_full = 0; m_rdy = 0; m_drop = 0;
      for (int k = 0; k < N; k++) begin sx[k] = 0; sy[k] = 0; sw[k] = 0; sh[k] = 0; sc[k] = 0; end
    end else begin
      h = int'(hcount); v = int'(vcount);
      pv = 1; px = 0; found = 0;
      if (!blank) begin
        for (int k = 0; k < N; k++)
          if (!found && sc[k] != 0 && h >= sx[k] && h < sx[k] + sw[k] &&
              v >= sy[k] && v < sy[k] + sh[k]) begin
            found = 1; px = sc[k];
          end
        if (!found) begin
          a = h % DEPTH;
          if (!memv[m_bank][a]) pv = 0;
          else if (v > mem[m_bank][a]) px = 'h00F;
          else if (LINE && v == mem[m_bank][a]) px = 'hFF0;
          else px = 'hFFF;
        end
      end
      e1 = px; e1v = pv;
      fe = m_vsq && !vsync;
      xf = wave_valid && m_rdy;
      fo = m_full;
      m_drop = fe && !fo;
      if (xf) begin
        mem[1-m_bank][m_idx] = int'(wave_prof);
        memv[1-m_bank][m_idx] = 1;
        if (m_idx == DEPTH-1) begin m_full = 1; m_idx = 0; end
        else m_idx++;
      end
      if (fe && fo) begin m_bank = 1 - m_bank; m_idx = 0; m_full = 0; end
      if (fe)
        for (int k = 0; k < N; k++) begin
          sx[k] = int'(spr_x[k*11 +: 11]); sy[k] = int'(spr_y[k*10 +: 10]);
          sw[k] = int'(spr_w[k*8 +: 8]);   sh[k] = int'(spr_h[k*8 +: 8]);
          sc[k] = int'(spr_rgb[k*12 +: 12]);
        end
      m_rdy = !m_full;
    end
    m_vsq = vsync;
  end

  always @(negedge vclock) begin
    if (started) begin
      if (e2v) chk("p_rgb_model", int'(p_rgb), e2);
      chk("wave_ready_model", int'(wave_ready), int'(m_rdy));
      chk("frame_drop_model", int'(frame_drop), int'(m_drop));
      if (frame_drop) drops++;
    end
  end

  task automatic vs_pulse();
    vsync = 1'b0;
    repeat (4) @(negedge vclock);
    vsync = 1'b1;
    repeat (4) @(negedge vclock);
  endtask

  task automatic pix(string nm, int h, int v, int exp);
    hcount = 11'(h); vcount = 10'(v); blank = 1'b0;
    repeat (2) @(negedge vclock);
    chk(nm, int'(p_rgb), exp);
  endtask

  // Streams n samples whose value equals their buffer index (base+i).
  task automatic load(int base, int n);
    int acc;
    acc = 0;
    for (int c = 0; c < 4*n + 10 && acc < n; c++) begin
      wave_valid = 1'b1;
      wave_prof = 10'(base + acc);
      if (wave_ready) acc++;
      @(negedge vclock);
    end
    wave_valid = 1'b0;
    chk("load_count", acc, n);
  endtask

  task automatic set_spr(int k, int x, int y, int w, int h, int c);
    spr_x[k*11 +: 11] = 11'(x); spr_y[k*10 +: 10] = 10'(y);
    spr_w[k*8 +: 8] = 8'(w);    spr_h[k*8 +: 8] = 8'(h);
    spr_rgb[k*12 +: 12] = 12'(c);
  endtask

  initial begin
    int acc, d0;
    reset = 1'b1;
    repeat (3) @(negedge vclock);
    chk("reset_p_rgb", int'(p_rgb), 0);
    chk("reset_ready", int'(wave_ready), 0);
    reset = 1'b0;
    @(negedge vclock);
    chk("ready_after_reset", int'(wave_ready), 1);

    // Held valid: reset after 300 accepts, then exactly DEPTH accepts.
    acc = 0; wave_prof = 10'd300; wave_valid = 1'b1;
    for (int c = 0; c < 400 && acc < 300; c++) begin
      if (wave_ready) acc++;
      @(negedge vclock);
    end
    reset = 1'b1;
    repeat (2) @(negedge vclock);
    chk("midload_reset_p_rgb", int'(p_rgb), 0);
    reset = 1'b0;
    acc = 0;
    for (int c = 0; c < 1200; c++) begin
      if (wave_ready) acc++;
      @(negedge vclock);
    end
    wave_valid = 1'b0;
    chk("held_accepts", acc, 1024);
    chk("ready_low_when_full", int'(wave_ready), 0);

    vs_pulse();
    pix("sky_299", 5, 299, 'hFFF);
    pix("sea_301", 5, 301, 'h00F);
    pix("row_300", 5, 300, LINE ? 'hFF0 : 'hFFF);
    pix("wrap_1029", 1029, 301, 'h00F);
    hcount = 11'd5; vcount = 10'd301; blank = 1'b1;
    repeat (2) @(negedge vclock);
    chk("blank_black", int'(p_rgb), 0);
    blank = 1'b0;

    // Partial load drops the swap; completing it swaps on the next frame.
    load(0, 500);
    d0 = drops; vs_pulse();
    chk("drop_once", drops - d0, 1);
    pix("bank_kept", 5, 301, 'h00F);
    load(500, 524);
    d0 = drops; vs_pulse();
    chk("no_drop_on_swap", drops - d0, 0);
    pix("new_sea", 5, 6, 'h00F);
    pix("new_sky", 5, 4, 'hFFF);

    set_spr(0, 100, 100, 10, 10, 'h0F0);
    set_spr(1, 105, 105, 10, 10, 'hF00);
    vs_pulse();
    pix("overlap_ch0", 106, 106, 'h0F0);
    pix("ch1_only", 112, 112, 'hF00);
    pix("past_ch0_bg", 110, 100, 'hFFF);
    set_spr(0, 500, 100, 10, 10, 'h0F0);
    pix("midframe_hold", 106, 106, 'h0F0);
    vs_pulse();
    pix("after_vsync", 106, 106, 'hF00);

    // Randomized traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      if (it % 250 == 0)
        for (int k = 0; k < N; k++)
          set_spr(k, $urandom_range(0, 1200), $urandom_range(0, 780),
                  $urandom_range(0, 60), $urandom_range(0, 60),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095));
      hcount = 11'($urandom_range(0, 1343));
      vcount = 10'($urandom_range(0, 805));
      blank = ($urandom_range(0, 7) == 0);
      wave_valid = 1'($urandom_range(0, 1));
      wave_prof = 10'($urandom_range(0, 767));
      vsync = !((it % 400) >= 395 && (it % 400) <= 397);
      @(negedge vclock);
    end
    wave_valid = 1'b0; vsync = 1'b1;
    repeat (3) @(negedge vclock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
